// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and types for the tone mixer datapath
// Contents: accumulator/gain widths, envelope and output scaling constants,
//           NOTE_NONE pitch marker, voice_state_t, sample_t, mixer FSM states.
package audio_pkg;

    localparam int ACC_W        = 20;
    localparam int GAIN_W       = 8;
    localparam int GAIN_MAX     = 255;
    localparam int ATTACK_STEP  = 16;
    localparam int RELEASE_STEP = 8;
    localparam int OUT_SHIFT    = 5;

    localparam logic [15:0] NOTE_NONE = 16'd1;

    typedef struct packed {
        logic [ACC_W-1:0]  phase;
        logic [GAIN_W-1:0] gain;
    } voice_state_t;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH0,
        ST_CH1,
        ST_CH2,
        ST_CH3
    } mix_state_t;

endpackage

// File: rtl/tone_voice_step.sv
// rtl/tone_voice_step.sv - combinational phase/envelope/contribution step for one voice
// Ports:
//   cur     in   current phase and gain of the selected channel
//   pitch   in   snapshotted pitch word (phase increment)
//   key     in   snapshotted key-held flag
//   nxt     out  phase and gain to write back
//   contrib out  signed square-wave contribution (+gain / -gain)
module tone_voice_step
    import audio_pkg::*;
(
    input  voice_state_t       cur,
    input  logic [15:0]        pitch,
    input  logic               key,
    output voice_state_t       nxt,
    output logic signed [9:0]  contrib
);

    logic              active;
    logic [ACC_W-1:0]  phase_sum;
    logic [GAIN_W:0]   gain_up;
    logic [GAIN_W-1:0] gain_new;

    always_comb begin
        active    = key && (pitch > NOTE_NONE);
        phase_sum = cur.phase + ACC_W'(pitch);
        gain_up   = {1'b0, cur.gain} + (GAIN_W+1)'(ATTACK_STEP);

        if (active) begin
            gain_new = (gain_up > (GAIN_W+1)'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX)
                                                         : gain_up[GAIN_W-1:0];
        end else begin
            gain_new = (cur.gain < GAIN_W'(RELEASE_STEP)) ? '0
                                                          : cur.gain - GAIN_W'(RELEASE_STEP);
        end

        nxt.gain = gain_new;
        // A fully released voice restarts at phase 0 so the next note begins in phase.
        nxt.phase = (!active && (gain_new == '0)) ? '0 : phase_sum;

        contrib = nxt.phase[ACC_W-1] ? -$signed({2'b00, gain_new})
                                     :  $signed({2'b00, gain_new});
    end

endmodule

// File: rtl/tone_mixer.sv
// rtl/tone_mixer.sv - four-voice square-wave synthesiser with envelopes and PCM handshake
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   sample_tick              one-clk strobe at the sample rate
//   sound1..sound4           per-channel pitch words (1 = no note)
//   sound_off1..sound_off4   1 = key held (channel active)
//   sample_data/valid/ready  signed PCM sample over valid/ready
//   channel_active           bit i set while channel i gain is nonzero
//   overrun_cnt              saturating count of dropped samples / ignored ticks
module tone_mixer
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [15:0] sound1,
    input  logic [15:0] sound2,
    input  logic [15:0] sound3,
    input  logic [15:0] sound4,
    input  logic        sound_off1,
    input  logic        sound_off2,
    input  logic        sound_off3,
    input  logic        sound_off4,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [3:0]  channel_active,
    output logic [7:0]  overrun_cnt
);

    mix_state_t           state, state_next;
    logic [3:0][15:0]     snap_sound;
    logic [3:0]           snap_key;
    voice_state_t [3:0]   voices;
    logic [11:0]          acc;
    logic [11:0]          acc_next;
    logic [1:0]           ch;
    logic                 in_ch;

    voice_state_t         step_state;
    logic signed [9:0]    step_contrib;

    logic                 out_overrun;
    logic                 tick_overrun;
    logic                 load_sample;
    logic [8:0]           ovr_sum;
    logic [7:0]           ovr_next;
    logic [15:0]          acc_ext;
    logic [15:0]          new_sample;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and channel select
    always_comb begin
        state_next = state;
        ch         = 2'd0;
        in_ch      = 1'b0;
        case (state)
            ST_IDLE: if (sample_tick) state_next = ST_CH0;
            ST_CH0: begin ch = 2'd0; in_ch = 1'b1; state_next = ST_CH1; end
            ST_CH1: begin ch = 2'd1; in_ch = 1'b1; state_next = ST_CH2; end
            ST_CH2: begin ch = 2'd2; in_ch = 1'b1; state_next = ST_CH3; end
            ST_CH3: begin ch = 2'd3; in_ch = 1'b1; state_next = ST_IDLE; end
            default: state_next = ST_IDLE;
        endcase
    end

    // One step unit shared by all channels through the ch mux
    tone_voice_step u_step (
        .cur     (voices[ch]),
        .pitch   (snap_sound[ch]),
        .key     (snap_key[ch]),
        .nxt     (step_state),
        .contrib (step_contrib)
    );

    always_comb begin
        acc_next     = acc + {{2{step_contrib[9]}}, step_contrib};
        acc_ext      = {{4{acc_next[11]}}, acc_next};
        new_sample   = acc_ext << OUT_SHIFT;

        // A sample still waiting on the serializer at the end of CH3 wins; the new one is dropped.
        out_overrun  = (state == ST_CH3) && sample_valid && !sample_ready;
        load_sample  = (state == ST_CH3) && !out_overrun;
        tick_overrun = sample_tick && (state != ST_IDLE);

        ovr_sum  = {1'b0, overrun_cnt} + {8'b0, out_overrun} + {8'b0, tick_overrun};
        ovr_next = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_sound     <= '0;
            snap_key       <= '0;
            voices         <= '0;
            acc            <= '0;
            sample_data    <= '0;
            sample_valid   <= 1'b0;
            channel_active <= '0;
            overrun_cnt    <= '0;
        end else begin
            if ((state == ST_IDLE) && sample_tick) begin
                snap_sound <= {sound4, sound3, sound2, sound1};
                snap_key   <= {sound_off4, sound_off3, sound_off2, sound_off1};
                acc        <= '0;
            end

            if (in_ch) begin
                voices[ch]         <= step_state;
                channel_active[ch] <= (step_state.gain != '0);
                acc                <= acc_next;
            end

            if (load_sample) begin
                sample_data  <= new_sample;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            overrun_cnt <= ovr_next;
        end
    end

endmodule

// File: tb/tb_tone_mixer.sv
// tb/tb_tone_mixer.sv - self-checking bench for tone_mixer
module tb_tone_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic        sample_ready;
    logic [15:0] snd [4];
    bit   [3:0]  key;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic [3:0]  channel_active;
    logic [7:0]  overrun_cnt;

    int tests = 0;
    int fails = 0;

    // reference model state
    longint m_phase [4];
    int     m_gain  [4];
    int     m_sample;
    logic [3:0] m_active;

    typedef struct packed {
        logic [3:0][15:0]    vsnd;
        logic [3:0]          vkey;
        logic signed [31:0]  exp_sample;
        logic [3:0]          exp_active;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    tone_mixer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_tick    (sample_tick),
        .sound1         (snd[0]),
        .sound2         (snd[1]),
        .sound3         (snd[2]),
        .sound4         (snd[3]),
        .sound_off1     (key[0]),
        .sound_off2     (key[1]),
        .sound_off3     (key[2]),
        .sound_off4     (key[3]),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .channel_active (channel_active),
        .overrun_cnt    (overrun_cnt)
    );

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0;
            m_gain[i]  = 0;
        end
        m_active = '0;
        m_sample = 0;
    endfunction

    // One sample period from the rules: advance phase, move gain toward target, mix.
    function automatic void m_tick();
        int s;
        bit act;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            act = key[i] && (snd[i] > 16'd1);
            m_phase[i] = (m_phase[i] + longint'(snd[i])) % (longint'(1) << 20);
            if (act) m_gain[i] = (m_gain[i] + 16 > 255) ? 255 : m_gain[i] + 16;
            else     m_gain[i] = (m_gain[i] < 8) ? 0 : m_gain[i] - 8;
            if (!act && m_gain[i] == 0) m_phase[i] = 0;
            s += (m_phase[i] >= (longint'(1) << 19)) ? -m_gain[i] : m_gain[i];
            m_active[i] = (m_gain[i] != 0);
        end
        m_sample = s * 32;
    endfunction

    task automatic set_inputs(logic [15:0] s0, logic [15:0] s1, logic [15:0] s2,
                              logic [15:0] s3, logic [3:0] k);
        snd[0] = s0; snd[1] = s1; snd[2] = s2; snd[3] = s3; key = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sample_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample_tick = ~sample_tick;
        end
        sample_tick = 1'b0;
        m_reset();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one tick, advances the model and waits (bounded) for the sample.
    task automatic run_tick(output int lat);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        m_tick();
        lat = 1;
        while (!sample_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic tick_vs_model(string name);
        int lat;
        run_tick(lat);
        check({name, " latency"}, lat, 5);
        check({name, " sample"}, $signed(sample_data), m_sample);
        check({name, " active"}, channel_active, m_active);
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_vs_const(string name, logic signed [31:0] es, logic [3:0] ea);
        int lat;
        run_tick(lat);
        check({name, " latency"}, lat, 5);
        check({name, " sample"}, $signed(sample_data), es);
        check({name, " active"}, channel_active, ea);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        int lat;
        logic signed [31:0] held;
        logic signed [31:0] seen;

        rst_n = 1'b0;
        sample_tick = 1'b0;
        sample_ready = 1'b1;
        set_inputs(16'd1, 16'd1, 16'd1, 16'd1, 4'b0000);

        // reset with ticks toggling
        do_reset();
        check("reset valid", sample_valid, 0);
        check("reset data", $signed(sample_data), 0);
        check("reset active", channel_active, 0);
        check("reset overrun", overrun_cnt, 0);
        release_reset();

        // table: attack from reset, second voice joins, releases
        vecs[0] = '{vsnd: {16'd1, 16'd1, 16'd1, 16'd565},    vkey: 4'b0001, exp_sample: 512,  exp_active: 4'b0001};
        vecs[1] = '{vsnd: {16'd1, 16'd1, 16'd1, 16'd565},    vkey: 4'b0001, exp_sample: 1024, exp_active: 4'b0001};
        vecs[2] = '{vsnd: {16'd1, 16'd1, 16'd1, 16'd565},    vkey: 4'b0001, exp_sample: 1536, exp_active: 4'b0001};
        vecs[3] = '{vsnd: {16'd1, 16'd1, 16'd1000, 16'd565}, vkey: 4'b0011, exp_sample: 2560, exp_active: 4'b0011};
        vecs[4] = '{vsnd: {16'd1, 16'd1, 16'd1000, 16'd565}, vkey: 4'b0010, exp_sample: 2816, exp_active: 4'b0011};
        vecs[5] = '{vsnd: {16'd1, 16'd1, 16'd1, 16'd565},    vkey: 4'b0010, exp_sample: 2304, exp_active: 4'b0011};
        for (int v = 0; v < 6; v++) begin
            set_inputs(vecs[v].vsnd[0], vecs[v].vsnd[1], vecs[v].vsnd[2], vecs[v].vsnd[3], vecs[v].vkey);
            tick_vs_const($sformatf("vec%0d", v), vecs[v].exp_sample, vecs[v].exp_active);
        end

        // attack to full scale and sign flip
        do_reset();
        release_reset();
        set_inputs(16'd565, 16'd1, 16'd1, 16'd1, 4'b0001);
        for (int t = 1; t <= 15; t++) tick_vs_model($sformatf("attack t%0d", t));
        tick_vs_const("attack t16", 8160, 4'b0001);
        for (int t = 17; t <= 926; t++) tick_vs_model("sustain");
        tick_vs_const("pre-flip t927", 8160, 4'b0001);
        tick_vs_const("flip t928", -8160, 4'b0001);

        // release to zero, then restart in phase
        key = 4'b0000;
        for (int t = 1; t <= 30; t++) tick_vs_model($sformatf("release t%0d", t));
        tick_vs_const("release t31", -224, 4'b0001);
        tick_vs_const("release t32", 0, 4'b0000);
        key = 4'b0001;
        tick_vs_const("note-on again", 512, 4'b0001);

        // full mix, then a NOTE_NONE pitch with key held releases
        do_reset();
        release_reset();
        set_inputs(16'd100, 16'd200, 16'd300, 16'd400, 4'b1111);
        for (int t = 1; t <= 15; t++) tick_vs_model("mix attack");
        tick_vs_const("full mix", 32640, 4'b1111);
        snd[2] = 16'd1;
        tick_vs_const("note none ch3", 32384, 4'b1111);

        // backpressure: first sample held, two overruns
        do_reset();
        release_reset();
        set_inputs(16'd565, 16'd1, 16'd1, 16'd1, 4'b0001);
        sample_ready = 1'b0;
        run_tick(lat);
        check("bp first latency", lat, 5);
        check("bp first sample", $signed(sample_data), 512);
        held = m_sample;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            run_tick(lat);
            repeat (4) @(negedge clk);
            check($sformatf("bp hold valid %0d", k), sample_valid, 1);
            check($sformatf("bp hold data %0d", k), $signed(sample_data), held);
        end
        check("bp overrun", overrun_cnt, 2);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check("bp valid drop", sample_valid, 0);
        sample_ready = 1'b1;
        tick_vs_const("bp after", 2048, 4'b0001);

        // tick while busy: second tick ignored
        do_reset();
        release_reset();
        set_inputs(16'd565, 16'd1, 16'd1, 16'd1, 4'b0001);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        m_tick();
        vcount = 0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (sample_valid) begin
                vcount++;
                seen = $signed(sample_data);
            end
            @(negedge clk);
        end
        check("busy sample count", vcount, 1);
        check("busy sample", seen, 512);
        check("busy overrun", overrun_cnt, 1);
        tick_vs_const("busy next", 1024, 4'b0001);

        // reset mid-computation leaves no partial sample
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m_reset();
        vcount = 0;
        for (int c = 0; c < 10; c++) begin
            if (sample_valid) vcount++;
            @(negedge clk);
        end
        check("abort no sample", vcount, 0);
        check("abort active", channel_active, 0);

        // randomized against the model
        set_inputs(16'd1, 16'd1, 16'd1, 16'd1, 4'b0000);
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) snd[i] = 16'($urandom_range(0, 1));
                else if ($urandom_range(0, 7) == 0) snd[i] = 16'($urandom);
                if ($urandom_range(0, 7) == 0) key[i] = ~key[i];
            end
            tick_vs_model($sformatf("rand t%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
